// File: rtl/tdm_tx_framer.sv
// tdm_tx_framer: G.704 E1 transmit framer, TS0 insertion and MSB-first serialiser.
// Define TX_FRAMER_CRC4_EN to build the CRC-4 generator and multiframe alignment bits.
module tdm_tx_framer #(
    parameter int          TICK_DIV  = 15,
    parameter logic [7:0]  IDLE_CODE = 8'hFF,
    parameter int          UFLOW_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic [1:0]         in_crc_e,
    input  logic               in_rdy,
    output logic               in_req,
    output logic [3:0]         in_frame,
    output logic [4:0]         in_ts,
    output logic               in_mf_first,
    output logic               in_mf_last,
    output logic               out_bit,
    output logic               out_valid,
    output logic               out_fsync,
    output logic               out_mfsync,
    input  logic               ctrl_time_src,
    input  logic               ctrl_do_framing,
    input  logic               ctrl_do_crc4,
    input  logic               ctrl_sa_ovr,
    input  logic [4:0]         ctrl_sa,
    input  logic [31:0]        ctrl_ts_idle,
    input  logic               alarm,
    input  logic               ext_tick,
    output logic               int_tick,
    output logic [UFLOW_W-1:0] uflow_cnt,
    input  logic               uflow_clr
);

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          ext_q;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    nxt;
    logic          nxt_fs;
    logic          nxt_mfs;
    logic [3:0]    frame;
    logic [4:0]    ts;
    logic          ts0_frm;
    logic          idle_sel;
    logic          uflow_evt;
    logic [7:0]    src;
    logic [7:0]    byte_c;
    logic          c_bit;
    logic          mf_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            ext_q    <= 1'b0;
            int_tick <= 1'b0;
        end else begin
            ext_q    <= ext_tick;
            div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            int_tick <= ctrl_time_src ? (ext_tick & ~ext_q)
                                      : (div_cnt == DIV_LAST);
        end
    end

    // Byte boundary on bit 0: load the prefetched byte, request the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= 3'd0;
            shreg      <= 8'hFF;
            out_bit    <= 1'b1;
            out_valid  <= 1'b0;
            out_fsync  <= 1'b0;
            out_mfsync <= 1'b0;
            in_req     <= 1'b0;
        end else begin
            out_valid  <= int_tick;
            in_req     <= int_tick && (bit_cnt == 3'd0);
            out_fsync  <= 1'b0;
            out_mfsync <= 1'b0;
            if (int_tick) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd0) begin
                    out_bit    <= nxt[7];
                    shreg      <= {nxt[6:0], 1'b1};
                    out_fsync  <= nxt_fs;
                    out_mfsync <= nxt_mfs;
                end else begin
                    out_bit <= shreg[7];
                    shreg   <= {shreg[6:0], 1'b1};
                end
            end
        end
    end

    assign in_frame    = frame;
    assign in_ts       = ts;
    assign in_mf_first = in_req && (frame == 4'd0) && (ts == 5'd0);
    assign in_mf_last  = in_req && (frame == 4'd15) && (ts == 5'd31);

`ifdef TX_FRAMER_CRC4_EN
    logic [3:0] crc;
    logic [3:0] c_reg;
    logic [7:0] mf_pat;
    logic [7:0] crc_in;

    function automatic logic [3:0] crc_byte(input logic [3:0] c,
                                            input logic [7:0] d);
        logic [3:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[3] ^ d[i];
            r  = {r[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return r;
    endfunction

    assign mf_pat = {in_crc_e, 6'b110100};
    assign crc_in = {byte_c[7] & ~(ts0_frm & ~frame[0] & ctrl_do_crc4),
                     byte_c[6:0]};

    // C bits read as ones until the first complete submultiframe
    always_ff @(posedge clk) begin
        if (rst) begin
            crc   <= 4'd0;
            c_reg <= 4'hF;
        end else if (in_req) begin
            if (ts == 5'd31 && frame[2:0] == 3'd7) begin
                c_reg <= crc_byte(crc, crc_in);
                crc   <= 4'd0;
            end else begin
                crc <= crc_byte(crc, crc_in);
            end
        end
    end
`else
    logic unused_crc;
    assign unused_crc = ^{in_crc_e, ctrl_do_crc4};
`endif

    always_comb begin
        ts0_frm   = (ts == 5'd0) && ctrl_do_framing;
        idle_sel  = ctrl_ts_idle[ts] && !ts0_frm;
        uflow_evt = in_req && !in_rdy && !idle_sel;
        src       = (in_rdy && !idle_sel) ? in_data : IDLE_CODE;
        c_bit     = src[7];
        mf_bit    = src[7];
`ifdef TX_FRAMER_CRC4_EN
        if (ctrl_do_crc4) begin
            c_bit  = c_reg[~frame[2:1]];
            mf_bit = mf_pat[frame[3:1]];
        end
`endif
        if (!ts0_frm)
            byte_c = src;
        else if (frame[0])
            byte_c = {mf_bit, 1'b1, alarm,
                      ctrl_sa_ovr ? ctrl_sa : src[4:0]};
        else
            byte_c = {c_bit, 7'b0011011};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame   <= 4'd0;
            ts      <= 5'd0;
            nxt     <= 8'hFF;
            nxt_fs  <= 1'b0;
            nxt_mfs <= 1'b0;
        end else if (in_req) begin
            nxt     <= byte_c;
            nxt_fs  <= (ts == 5'd0);
            nxt_mfs <= (ts == 5'd0) && (frame == 4'd0);
            ts      <= ts + 5'd1;
            if (ts == 5'd31)
                frame <= frame + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            uflow_cnt <= '0;
        else if (uflow_clr)
            uflow_cnt <= '0;
        else if (uflow_evt && !(&uflow_cnt))
            uflow_cnt <= uflow_cnt + 1'b1;
    end

endmodule
